pipe_stage_buf: RTL



---
 rtl/pipe_stage_buf.sv | 158 +++++++++++++++
 1 files changed

// File: rtl/pipe_stage_buf.sv
// Inter-stage valid/ready latch with 2-entry skid buffer, flush-to-bubble and global freeze; 1-cycle latency.
// in_ready comes from registers only (skid full or frozen), so no combinational ready path crosses stages.
// Optional saturating stall/bubble counters are built when PIPE_STAGE_STATS_EN is defined.
module pipe_stage_buf #(
    parameter int DATA_W = 133,
    parameter int CTRL_W = 3,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cpu_en,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [DATA_W-1:0] out_data,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic [CNT_W-1:0]  bubble_cnt
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic              main_valid;
    logic              skid_valid;
    logic [CTRL_W-1:0] main_ctrl;
    logic [CTRL_W-1:0] skid_ctrl;
    logic [DATA_W-1:0] main_data;
    logic [DATA_W-1:0] skid_data;
    logic              accept;
    logic              drain;
    logic              load_main_in;
    logic              load_main_skid;
    logic              load_skid_in;

    assign main_valid = (state == ONE) || (state == TWO);
    assign skid_valid = (state == TWO);
    assign accept     = in_valid & in_ready;
    assign drain      = out_valid & out_ready;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= EMPTY;
        end else if (flush) begin
            state <= EMPTY;
        end else if (cpu_en) begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt      = state;
        load_main_in   = 1'b0;
        load_main_skid = 1'b0;
        load_skid_in   = 1'b0;
        case (state)
            EMPTY: begin
                if (accept) begin
                    state_nxt    = ONE;
                    load_main_in = 1'b1;
                end
            end
            ONE: begin
                if (accept && drain) begin
                    load_main_in = 1'b1;
                end else if (accept) begin
                    state_nxt    = TWO;
                    load_skid_in = 1'b1;
                end else if (drain) begin
                    state_nxt = EMPTY;
                end
            end
            TWO: begin
                // skid is always older than anything arriving, so it refills main first
                if (drain) begin
                    state_nxt      = ONE;
                    load_main_skid = 1'b1;
                end
            end
            default: state_nxt = EMPTY;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            main_ctrl <= '0;
            skid_ctrl <= '0;
        end else if (flush) begin
            main_ctrl <= '0;
            skid_ctrl <= '0;
        end else if (cpu_en) begin
            if (load_main_in) begin
                main_ctrl <= in_ctrl;
            end else if (load_main_skid) begin
                main_ctrl <= skid_ctrl;
            end
            if (load_skid_in) begin
                skid_ctrl <= in_ctrl;
            end
        end
    end

    // payload needs no reset: it is only observed while the matching valid is set
    always_ff @(posedge clk) begin
        if (!flush && cpu_en) begin
            if (load_main_in) begin
                main_data <= in_data;
            end else if (load_main_skid) begin
                main_data <= skid_data;
            end
            if (load_skid_in) begin
                skid_data <= in_data;
            end
        end
    end

    always_comb begin
        in_ready  = cpu_en & ~skid_valid;
        out_valid = cpu_en & main_valid;
        out_ctrl  = out_valid ? main_ctrl : '0;
        out_data  = main_data;
    end

`ifdef PIPE_STAGE_STATS_EN
    logic [CNT_W-1:0] stall_q;
    logic [CNT_W-1:0] bubble_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stall_q  <= '0;
            bubble_q <= '0;
        end else begin
            if (cpu_en && main_valid && !out_ready && (stall_q != '1)) begin
                stall_q <= stall_q + 1'b1;
            end
            if (cpu_en && !main_valid && (bubble_q != '1)) begin
                bubble_q <= bubble_q + 1'b1;
            end
        end
    end

    assign stall_cnt  = stall_q;
    assign bubble_cnt = bubble_q;
`else
    assign stall_cnt  = '0;
    assign bubble_cnt = '0;
`endif

endmodule
